// File: rtl/hdmi_rx_align_ctrl.sv
//------------------------------------------------------------------------------
// hdmi_rx_align_ctrl
//
// Word-alignment controller for one HDMI RX TMDS channel. Watches the raw
// 10-bit words from the channel deserializer, ahead of the TMDS decoder. While
// no run of control tokens is seen, it steps the deserializer one bit at a
// time using single-cycle bitslip pulses. Control tokens only appear during
// blanking, so a long enough run of them marks the correct word boundary.
// Lock is dropped when control tokens stop arriving for too long.
//
// Parameters
//   CTRL_RUN     consecutive control tokens needed to declare lock
//   SEARCH_WIN   cycles spent searching at one slip position before slipping
//   SETTLE       cycles ignored after each bitslip pulse
//   LOSS_CYCLES  cycles without any control token before lock is dropped
//
// Ports
//   i_pixclk        pixel clock; the only clock
//   i_rst           synchronous, active-high reset
//   i_encoded_data  raw deserialized TMDS word
//   o_bitslip       one-cycle slip request to the deserializer
//   o_aligned       channel is word-aligned
//   o_slip_count    current slip position, 0..9
//   o_align_err     sticky; all 10 slip positions tried without lock
//
// State table
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_SEARCH  | count token runs and search-window cycles at this position
//   ST_SLIP    | one-cycle bitslip pulse; slip position advances
//   ST_SETTLE  | wait for the deserializer output to settle; data ignored
//   ST_LOCKED  | aligned; watch for loss of control tokens
//------------------------------------------------------------------------------
module hdmi_rx_align_ctrl #(
   parameter int CTRL_RUN    = 8,
   parameter int SEARCH_WIN  = 4096,
   parameter int SETTLE      = 16,
   parameter int LOSS_CYCLES = 1048576
) (
   input  logic       i_pixclk,
   input  logic       i_rst,
   input  logic [9:0] i_encoded_data,
   output logic       o_bitslip,
   output logic       o_aligned,
   output logic [3:0] o_slip_count,
   output logic       o_align_err
);

   localparam int RUN_W    = (CTRL_RUN    > 1) ? $clog2(CTRL_RUN)    : 1;
   localparam int WIN_W    = (SEARCH_WIN  > 1) ? $clog2(SEARCH_WIN)  : 1;
   localparam int SETTLE_W = (SETTLE      > 1) ? $clog2(SETTLE)      : 1;
   localparam int LOSS_W   = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;

   localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(CTRL_RUN - 1);
   localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(SEARCH_WIN - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
   localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_CYCLES - 1);

   localparam logic [9:0] TOKEN_0 = 10'b1101010100;
   localparam logic [9:0] TOKEN_1 = 10'b0010101011;
   localparam logic [9:0] TOKEN_2 = 10'b0101010100;
   localparam logic [9:0] TOKEN_3 = 10'b1010101011;

   localparam logic [3:0] SLIP_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t              state;
   logic [9:0]          r_data;
   logic                is_token;
   logic [RUN_W-1:0]    run_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [LOSS_W-1:0]   loss_cnt;

   // Token decode looks at the registered word, so the FSM acts on each word
   // one edge after it is captured.
   assign is_token = (r_data == TOKEN_0) || (r_data == TOKEN_1) ||
                     (r_data == TOKEN_2) || (r_data == TOKEN_3);

   always_ff @(posedge i_pixclk) begin
      if (i_rst) begin
         state        <= ST_SEARCH;
         r_data       <= '0;
         run_cnt      <= '0;
         win_cnt      <= '0;
         settle_cnt   <= '0;
         loss_cnt     <= '0;
         o_bitslip    <= 1'b0;
         o_aligned    <= 1'b0;
         o_slip_count <= '0;
         o_align_err  <= 1'b0;
      end else begin
         r_data <= i_encoded_data;

         case (state)
            ST_SEARCH: begin
               // Lock is tested first so it wins over an expiring window.
               if (is_token && (run_cnt == RUN_LAST)) begin
                  state       <= ST_LOCKED;
                  o_aligned   <= 1'b1;
                  o_align_err <= 1'b0;
                  run_cnt     <= '0;
                  win_cnt     <= '0;
                  loss_cnt    <= '0;
               end else if (win_cnt == WIN_LAST) begin
                  state     <= ST_SLIP;
                  o_bitslip <= 1'b1;
                  run_cnt   <= '0;
                  win_cnt   <= '0;
                  if (o_slip_count == SLIP_MAX) begin
                     o_slip_count <= '0;
                     o_align_err  <= 1'b1;
                  end else begin
                     o_slip_count <= o_slip_count + 4'd1;
                  end
               end else begin
                  run_cnt <= is_token ? (run_cnt + RUN_W'(1)) : '0;
                  win_cnt <= win_cnt + WIN_W'(1);
               end
            end

            ST_SLIP: begin
               state      <= ST_SETTLE;
               o_bitslip  <= 1'b0;
               settle_cnt <= SETTLE_LAST;
            end

            ST_SETTLE: begin
               run_cnt <= '0;
               win_cnt <= '0;
               if (settle_cnt == '0) begin
                  state <= ST_SEARCH;
               end else begin
                  settle_cnt <= settle_cnt - SETTLE_W'(1);
               end
            end

            ST_LOCKED: begin
               if (!is_token && (loss_cnt == LOSS_LAST)) begin
                  // Slip position is kept: the link most likely just lost
                  // blanking, so searching resumes from the last good offset.
                  state     <= ST_SEARCH;
                  o_aligned <= 1'b0;
                  run_cnt   <= '0;
                  win_cnt   <= '0;
                  loss_cnt  <= '0;
               end else begin
                  loss_cnt <= is_token ? '0 : (loss_cnt + LOSS_W'(1));
               end
            end

            default: begin
               state     <= ST_SEARCH;
               o_bitslip <= 1'b0;
               o_aligned <= 1'b0;
               run_cnt   <= '0;
               win_cnt   <= '0;
               loss_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hdmi_rx_align_ctrl.sv
//------------------------------------------------------------------------------
// tb_hdmi_rx_align_ctrl
//
// Directed bench for hdmi_rx_align_ctrl with small parameters. The stimulus
// thread pushes the expected output events (bitslip pulses, aligned rise and
// fall) with the cycle they must appear in; a monitor on the falling edge pops
// and compares whenever the DUT produces such an event.
//------------------------------------------------------------------------------
module tb_hdmi_rx_align_ctrl;

   localparam int CTRL_RUN    = 8;
   localparam int SEARCH_WIN  = 64;
   localparam int SETTLE      = 4;
   localparam int LOSS_CYCLES = 32;

   localparam logic [9:0] NT = 10'h155;

   localparam logic [1:0] EV_SLIP = 2'd0;
   localparam logic [1:0] EV_RISE = 2'd1;
   localparam logic [1:0] EV_FALL = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      int         cyc;
      logic [3:0] slip;
      logic       err;
   } ev_t;

   logic       i_pixclk = 1'b0;
   logic       i_rst    = 1'b1;
   logic [9:0] i_encoded_data = 10'h3FF;
   logic       o_bitslip;
   logic       o_aligned;
   logic [3:0] o_slip_count;
   logic       o_align_err;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   rel   = 0;
   int   tok_i = 0;
   ev_t  exp_q[$];
   logic prev_al = 1'b0;
   logic prev_bs = 1'b0;
   logic [9:0] toks [4];

   hdmi_rx_align_ctrl #(
      .CTRL_RUN   (CTRL_RUN),
      .SEARCH_WIN (SEARCH_WIN),
      .SETTLE     (SETTLE),
      .LOSS_CYCLES(LOSS_CYCLES)
   ) dut (
      .i_pixclk      (i_pixclk),
      .i_rst         (i_rst),
      .i_encoded_data(i_encoded_data),
      .o_bitslip     (o_bitslip),
      .o_aligned     (o_aligned),
      .o_slip_count  (o_slip_count),
      .o_align_err   (o_align_err)
   );

   always #5 i_pixclk = ~i_pixclk;

   always @(posedge i_pixclk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input logic [1:0] kind, input int c, input logic [3:0] slip,
                          input logic err);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.slip = slip;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic match_ev(input logic [1:0] kind);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d cyc=%0d slip=%0d err=%0d, none expected",
                  kind, cyc, o_slip_count, o_align_err);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.cyc !== cyc || e.slip !== o_slip_count ||
             e.err !== o_align_err) begin
            bad++;
            $display("FAIL event: got kind=%0d cyc=%0d slip=%0d err=%0d expected kind=%0d cyc=%0d slip=%0d err=%0d",
                     kind, cyc, o_slip_count, o_align_err, e.kind, e.cyc, e.slip, e.err);
         end
      end
   endtask

   // Monitor: sample away from the active edge.
   always @(negedge i_pixclk) begin
      if (o_aligned !== prev_al) match_ev(o_aligned ? EV_RISE : EV_FALL);
      if (o_bitslip === 1'b1) begin
         check("bitslip_single_cycle", prev_bs, 0);
         check("bitslip_not_locked", o_aligned, 0);
         match_ev(EV_SLIP);
      end
      prev_al = o_aligned;
      prev_bs = o_bitslip;
   end

   // Each call presents one word that is captured at the next rising edge;
   // on return cyc is the index of that capturing edge.
   task automatic drive(input logic [9:0] w);
      i_encoded_data = w;
      @(posedge i_pixclk);
      #1;
   endtask

   task automatic drive_n(input logic [9:0] w, input int n);
      repeat (n) drive(w);
   endtask

   task automatic drive_tokens(input int n);
      repeat (n) begin
         drive(toks[tok_i % 4]);
         tok_i++;
      end
   endtask

   task automatic do_reset(input int n, input logic aligned_now);
      if (aligned_now) push_ev(EV_FALL, cyc + 1, 4'd0, 1'b0);
      i_rst = 1'b1;
      repeat (n) drive(NT);
      i_rst = 1'b0;
      rel = cyc;
   endtask

   int c1;

   initial begin
      toks[0] = 10'b1101010100;
      toks[1] = 10'b0010101011;
      toks[2] = 10'b0101010100;
      toks[3] = 10'b1010101011;

      // 1: reset with arbitrary data
      i_rst = 1'b1;
      drive(10'h3FF);
      drive(toks[0]);
      drive(10'h000);
      i_rst = 1'b0;
      rel = cyc;
      check("reset_bitslip", o_bitslip, 0);
      check("reset_aligned", o_aligned, 0);
      check("reset_slip_count", o_slip_count, 0);
      check("reset_align_err", o_align_err, 0);

      // 2: immediate lock
      push_ev(EV_RISE, rel + 9, 4'd0, 1'b0);
      drive_n(toks[0], 8);
      check("lock_not_early", o_aligned, 0);
      drive_n(toks[0], 2);
      check("lock_aligned", o_aligned, 1);
      check("lock_slip_count", o_slip_count, 0);

      // 4: broken run
      do_reset(2, 1'b1);
      push_ev(EV_RISE, rel + 17, 4'd0, 1'b0);
      drive_tokens(7);
      drive(NT);
      check("broken_no_lock_after_7", o_aligned, 0);
      drive_tokens(8);
      check("broken_not_early", o_aligned, 0);

      // 5: loss of lock
      repeat (4) begin
         drive_n(NT, 30);
         drive_tokens(1);
      end
      check("loss_kept_by_tokens", o_aligned, 1);
      c1 = cyc + 1;
      push_ev(EV_FALL, c1 + 32, 4'd0, 1'b0);
      push_ev(EV_SLIP, c1 + 32 + 64, 4'd1, 1'b0);
      drive_n(NT, 32);
      check("loss_still_aligned", o_aligned, 1);
      drive(NT);
      check("loss_dropped", o_aligned, 0);
      drive_n(NT, 63);
      check("loss_slip_count_kept", o_slip_count, 0);
      drive(NT);
      check("loss_slip_pulse", o_bitslip, 1);
      check("loss_slip_count_step", o_slip_count, 1);
      drive_n(NT, 3);

      // 3: slip sweep
      do_reset(2, 1'b0);
      for (int k = 0; k < 10; k++)
         push_ev(EV_SLIP, rel + 64 + 69 * k, 4'((k + 1) % 10), (k == 9));
      drive_n(NT, 700);
      check("sweep_err_sticky", o_align_err, 1);
      check("sweep_slip_wrapped", o_slip_count, 0);
      push_ev(EV_RISE, cyc + 9, 4'd0, 1'b0);
      drive_tokens(8);
      drive_tokens(2);
      check("sweep_lock", o_aligned, 1);
      check("sweep_err_cleared", o_align_err, 0);

      // 6: reset mid-slip
      do_reset(2, 1'b1);
      push_ev(EV_SLIP, rel + 64, 4'd1, 1'b0);
      drive_n(NT, 64);
      check("midslip_pulse_high", o_bitslip, 1);
      i_rst = 1'b1;
      drive(NT);
      check("midslip_bitslip_cleared", o_bitslip, 0);
      check("midslip_slip_count_cleared", o_slip_count, 0);
      i_rst = 1'b0;
      rel = cyc;
      push_ev(EV_SLIP, rel + 64, 4'd1, 1'b0);
      drive_n(NT, 66);

      drive_n(NT, 4);
      check("pending_events", exp_q.size(), 0);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         $display("FAIL missing_event: kind=%0d cyc=%0d never seen", e.kind, e.cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hdmi_rx_align_ctrl.md
# hdmi_rx_align_ctrl

Word-alignment controller for one HDMI RX TMDS channel. Monitors raw 10-bit words from the channel deserializer ahead of the TMDS decoder. Issues single-cycle bitslip requests to the deserializer until runs of TMDS control tokens appear, which happens during blanking. Declares lock for the decoder and downstream logic and drops lock when control tokens stop arriving.

## Interface
- CTRL_RUN, 8: consecutive control tokens required to declare lock
- SEARCH_WIN, 4096: cycles spent searching at one slip position before slipping
- SETTLE, 16: cycles ignored after each bitslip pulse
- LOSS_CYCLES, 1048576: cycles without any control token before lock is dropped
- i_pixclk  input  1  pixel clock; the only clock
- i_rst  input  1  synchronous, active-high reset
- i_encoded_data  input  10  raw deserialized TMDS word
- o_bitslip  output  1  one-cycle slip request to the deserializer
- o_aligned  output  1  channel word-aligned
- o_slip_count  output  4  current slip position, 0..9
- o_align_err  output  1  sticky; set when all 10 slip positions have been tried without lock

## Operation
- Control tokens are 10'b1101010100, 10'b0010101011, 10'b0101010100 and 10'b1010101011. Any other word is a non-token.
- i_encoded_data is registered once into r_data. The token flag is decoded combinationally from r_data.
- The state machine has four states: SEARCH, SLIP, SETTLE, LOCKED. Reset state is SEARCH.
- **SEARCH**
  - Run counter increments on a token and clears to 0 on a non-token.
  - Window counter increments every cycle.
  - If a token arrives while run counter == CTRL_RUN-1: go to LOCKED.
  - Otherwise, if window counter == SEARCH_WIN-1: go to SLIP.
  - If both conditions are true in the same cycle, lock wins.
- **SLIP**
  - Lasts exactly one cycle, with o_bitslip = 1.
  - o_slip_count increments modulo 10.
  - On the 9→0 wrap, o_align_err is set.
  - Next state is SETTLE.
- **SETTLE**
  - Lasts SETTLE cycles; data is ignored.
  - Run counter and window counter are held at 0.
  - Next state is SEARCH.
- **LOCKED**
  - o_aligned = 1 and o_align_err is cleared.
  - Loss counter clears on every token and increments otherwise.
  - If a non-token arrives while loss counter == LOSS_CYCLES-1: go to SEARCH with o_aligned = 0. All counters clear; o_slip_count is kept.
- Counter widths are $clog2 of the respective parameter (minimum 1 bit). Counters saturate to nothing, because every terminal count forces a state change.
- o_bitslip never asserts in LOCKED or SETTLE, and never for two consecutive cycles.

## Timing
- **Reset values:** o_bitslip = 0, o_aligned = 0, o_slip_count = 0, o_align_err = 0, state = SEARCH, all counters 0.
- **Reset priority:** i_rst dominates all states. An o_bitslip high in the cycle reset is sampled is low after that edge.
- **All outputs are registered.**
  - o_aligned and o_bitslip equal (state == LOCKED) and (state == SLIP) respectively.
  - Each is updated at the same edge as the state.
- **Lock latency:** the CTRL_RUN-th consecutive token is presented before edge t and captured in r_data at t. State becomes LOCKED and o_aligned = 1 after edge t+1.
- **Loss latency:** o_aligned falls after the edge that processes the LOSS_CYCLES-th consecutive non-token in r_data.
- **Slip period with no lock:** SEARCH_WIN + 1 + SETTLE cycles.
  - The first o_bitslip is high in cycle SEARCH_WIN+1 after reset deasserts, counting the first post-reset cycle as 1.
- **Deserializer requirement:** o_bitslip is a level, high for exactly one i_pixclk cycle. The deserializer must shift by one bit per pulse.

## Test plan
All scenarios use CTRL_RUN=8, SEARCH_WIN=64, SETTLE=4, LOSS_CYCLES=32.

1. **Reset:** hold i_rst for 3 cycles with arbitrary data → all outputs 0; no o_bitslip during reset.
2. **Immediate lock:** after reset, drive 8 consecutive 10'b1101010100 → o_aligned = 1 two edges after the 8th word is presented; o_bitslip never asserts; o_slip_count = 0.
3. **Slip sweep:** drive constant 10'h155 with no tokens.
   - o_bitslip pulses last one cycle each, every 69 cycles.
   - The first pulse is in cycle 65.
   - o_slip_count steps 1..9 then 0.
   - o_align_err rises at the 10th pulse and stays high.
   - Then drive 8 tokens → lock, and o_align_err clears.
4. **Broken run:** drive 7 tokens, 1 word of 10'h155, then 8 tokens → no lock after the first 7; lock two edges after the 8th token of the second run.
5. **Loss of lock:**
   - Once locked, a token every 31 cycles → o_aligned stays 1.
   - Then 32 consecutive non-tokens → o_aligned falls.
   - A slip occurs 64 cycles later if no tokens arrive; o_slip_count is unchanged until that slip.
6. **Reset mid-slip:** assert i_rst in the cycle o_bitslip = 1 → after that edge, o_bitslip = 0 and o_slip_count = 0; the next pulse comes 64 cycles after reset release.
